// File: rtl/axis_nibble_unpacker.sv
// rtl/axis_nibble_unpacker.sv - 16-bit keep-qualified stream to narrow nibble-beat unpacker
//
// Accepts 16-bit beats whose keep is a bit count (4/8/12/16), stores the nibbles
// in a circular FIFO with a per-nibble end-of-packet flag, and re-emits each
// packet as beats of 1..4 nibbles. The final beat of a packet carries the remainder.
//
// Ports:
//   clk, arst              clock, asynchronous active-low reset
//   s_data/s_keep/s_valid/s_last/s_ready   wide input stream (keep = valid bit count)
//   chunk                  nibbles per output beat (0 or >4 treated as 4), sampled at packet start
//   m_data/m_keep/m_valid/m_last/m_ready   narrow output stream (LSB-aligned, keep = bit count)
//   err_keep               one-cycle pulse after accepting a beat with zero/illegal keep
//   fill                   nibbles held in the FIFO (not counting the output register)
//   pkt_cnt, err_cnt       packet / keep-error counters, only with NIBBLE_UNPACK_STATS_EN

module axis_nibble_unpacker #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [15:0] s_data,
    input  logic [7:0]  s_keep,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic [2:0]  chunk,
    output logic [15:0] m_data,
    output logic [7:0]  m_keep,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        err_keep,
`ifdef NIBBLE_UNPACK_STATS_EN
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt,
`endif
    output logic [AW:0] fill
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_nx;
    logic [3:0]       mem [DEPTH];
    logic [DEPTH-1:0] eop;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [2:0]       chunk_q;

    logic [2:0]       wr_k;
    logic             s_acc;
    logic [2:0]       wr_n;
    logic [2:0]       chunk_in, chunk_eff;
    logic [2:0]       eop_n;
    logic [2:0]       cand;
    logic             take;
    logic             load;
    logic [2:0]       rd_n;
    logic [15:0]      beat_data;
    logic [AW:0]      free_slots;

    // Keep is a bit count; anything outside {4,8,12,16} maps to zero nibbles.
    always_comb begin
        case (s_keep)
            8'd4:    wr_k = 3'd1;
            8'd8:    wr_k = 3'd2;
            8'd12:   wr_k = 3'd3;
            8'd16:   wr_k = 3'd4;
            default: wr_k = 3'd0;
        endcase
    end

    assign free_slots = (AW+1)'(DEPTH) - fill;
    assign s_ready    = arst & (free_slots >= (AW+1)'(4));
    assign s_acc      = s_valid & s_ready;
    assign wr_n       = s_acc ? wr_k : 3'd0;

    assign chunk_in  = ((chunk == 3'd0) || (chunk > 3'd4)) ? 3'd4 : chunk;
    // In IDLE the first beat of a packet is sized with the live chunk value so
    // that it can load in the same cycle the chunk is latched.
    assign chunk_eff = (state == IDLE) ? chunk_in : chunk_q;

    // Smallest inclusive distance to an EOP among the stored nibbles inside the
    // beat window; descending loop lets the nearest flag win.
    always_comb begin
        eop_n = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if ((3'(i) < chunk_eff) && ((AW+1)'(i) < fill) && eop[rd_ptr + AW'(i)])
                eop_n = 3'(i + 1);
        end
    end

    always_comb begin
        cand = 3'd0;
        if (eop_n != 3'd0)
            cand = eop_n;
        else if (fill >= (AW+1)'(chunk_eff))
            cand = chunk_eff;
    end

    assign take = m_valid & m_ready;
    // A pending last beat blocks further loads so the next packet re-samples chunk.
    assign load = (fill != '0) && (!m_valid || (take && !m_last)) && (cand != 3'd0);
    assign rd_n = load ? cand : 3'd0;

    always_comb begin
        beat_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < cand)
                beat_data[4*i +: 4] = mem[rd_ptr + AW'(i)];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (fill != '0) state_nx = SEND;
            SEND: if (take && m_last) state_nx = IDLE;
        endcase
    end

    // Nibble storage needs no reset: only positions between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < wr_n)
                mem[wr_ptr + AW'(i)] <= s_data[4*i +: 4];
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            eop      <= '0;
            chunk_q  <= 3'd4;
            m_data   <= '0;
            m_keep   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            err_keep <= 1'b0;
        end else begin
            state    <= state_nx;
            err_keep <= s_acc && (wr_k == 3'd0);
            if ((state == IDLE) && (fill != '0))
                chunk_q <= chunk_in;
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < wr_n)
                    eop[wr_ptr + AW'(i)] <= s_last && (3'(i + 1) == wr_n);
            end
            wr_ptr <= wr_ptr + AW'(wr_n);
            rd_ptr <= rd_ptr + AW'(rd_n);
            fill   <= fill + (AW+1)'(wr_n) - (AW+1)'(rd_n);
            if (load) begin
                m_data  <= beat_data;
                m_keep  <= {3'b000, cand, 2'b00};
                m_valid <= 1'b1;
                m_last  <= (eop_n != 3'd0);
            end else if (take) begin
                m_data  <= '0;
                m_keep  <= '0;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

`ifdef NIBBLE_UNPACK_STATS_EN
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (take && m_last)
                pkt_cnt <= pkt_cnt + 16'd1;
            if (err_keep)
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
